// File: rtl/fp8_div_iterative.sv
// fp8_div_iterative: multi-cycle restoring divider for the 8-bit lab float
// {S, E[2:0], M[3:0]}, value = (-1)^S * 1.M * 2^(E-BIAS), E==0 encodes zero.
// Produces one quotient bit per clock, then normalises, rounds to nearest-even
// and range-checks. One operation in flight, valid/ready on both sides.
// Optional feature macro: FPDIV_EARLY_EXIT_EN -- zero-dividend and
// divide-by-zero operands skip DIVIDE/ROUND and complete on the accept edge.
module fp8_div_iterative #(
  parameter int BIAS  = 3,
  parameter int QBITS = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] q,
  output logic [3:0] flags
);

  localparam int CW = $clog2(QBITS);

`ifdef FPDIV_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_ROUND  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Result for zero-dividend / divide-by-zero operands: {q, flags}.
  function automatic logic [11:0] special_result(input logic sq, input logic eb_zero);
    logic [11:0] res;
    if (eb_zero) begin
      res = {sq, 7'h7F, 4'b1000};
    end else begin
      res = {sq, 7'h00, 4'b0000};
    end
    return res;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               r_sq, w_sq_nxt;
  logic               r_ea_zero, w_ea_zero_nxt;
  logic               r_eb_zero, w_eb_zero_nxt;
  logic [4:0]         r_mb, w_mb_nxt;
  logic [5:0]         r_rem, w_rem_nxt;
  logic [QBITS-1:0]   r_quo, w_quo_nxt;
  logic signed [4:0]  r_ep, w_ep_nxt;
  logic               r_in_ready, w_in_ready_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [7:0]         r_q, w_q_nxt;
  logic [3:0]         r_flags, w_flags_nxt;

  // Operand decode and one restoring-division step.
  logic               w_a_ez, w_b_ez;
  logic signed [4:0]  w_ep_in;
  logic [6:0]         w_trial;
  logic               w_qbit;
  logic [5:0]         w_rem_step;

  // Normalise / round datapath (used in ROUND).
  logic [3:0]         w_m_pre;
  logic               w_g, w_r, w_s, w_up;
  logic signed [4:0]  w_ep_n, w_ep_f;
  logic [4:0]         w_m_sum;
  logic               w_ovf, w_unf;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign q         = r_q;
  assign flags     = r_flags;

  // Operand field decode and the trial subtraction of one division step.
  always_comb begin
    w_a_ez  = (a[6:4] == 3'd0);
    w_b_ez  = (b[6:4] == 3'd0);
    w_ep_in = $signed({2'b00, a[6:4]}) - $signed({2'b00, b[6:4]}) + $signed(5'(BIAS));
    w_trial = {1'b0, r_rem} - {2'b00, r_mb};
    if (!w_trial[6]) begin
      // Remainder covers the divisor: subtract, quotient bit 1.
      w_qbit     = 1'b1;
      w_rem_step = {w_trial[4:0], 1'b0};
    end else begin
      // Restore: keep the remainder, quotient bit 0.
      w_qbit     = 1'b0;
      w_rem_step = {r_rem[4:0], 1'b0};
    end
  end

  // Normalise, round-to-nearest-even and range check of the raw quotient.
  always_comb begin
    if (r_quo[QBITS-1]) begin
      w_m_pre = r_quo[5:2];
      w_g     = r_quo[1];
      w_r     = r_quo[0];
      w_ep_n  = r_ep;
    end else begin
      // Quotient below 1.0: shift left one place, exponent drops by one.
      w_m_pre = r_quo[4:1];
      w_g     = r_quo[0];
      w_r     = 1'b0;
      w_ep_n  = r_ep - 5'sd1;
    end
    w_s     = |r_rem;
    w_up    = w_g & (w_r | w_s | w_m_pre[0]);
    w_m_sum = {1'b0, w_m_pre} + {4'b0000, w_up};
    // Mantissa carry-out (1.1111 + ulp) renormalises to 10.0000.
    if (w_m_sum[4]) begin
      w_ep_f = w_ep_n + 5'sd1;
    end else begin
      w_ep_f = w_ep_n;
    end
    w_ovf = (w_ep_f > 5'sd7);
    w_unf = (w_ep_f < 5'sd1);
  end

  // Next-state and next-register logic for the IDLE/DIVIDE/ROUND/DONE sequence.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_sq_nxt        = r_sq;
    w_ea_zero_nxt   = r_ea_zero;
    w_eb_zero_nxt   = r_eb_zero;
    w_mb_nxt        = r_mb;
    w_rem_nxt       = r_rem;
    w_quo_nxt       = r_quo;
    w_ep_nxt        = r_ep;
    w_out_valid_nxt = r_out_valid;
    w_q_nxt         = r_q;
    w_flags_nxt     = r_flags;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_sq_nxt      = a[7] ^ b[7];
          w_ea_zero_nxt = w_a_ez;
          w_eb_zero_nxt = w_b_ez;
          w_mb_nxt      = {1'b1, b[3:0]};
          w_rem_nxt     = {2'b01, a[3:0]};
          w_quo_nxt     = '0;
          w_ep_nxt      = w_ep_in;
          w_cnt_nxt     = '0;
          if (EARLY_EXIT && (w_a_ez || w_b_ez)) begin
            {w_q_nxt, w_flags_nxt} = special_result(a[7] ^ b[7], w_b_ez);
            w_out_valid_nxt        = 1'b1;
            w_state_nxt            = S_DONE;
          end else begin
            w_state_nxt = S_DIVIDE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DIVIDE: begin
        w_rem_nxt = w_rem_step;
        w_quo_nxt = {r_quo[QBITS-2:0], w_qbit};
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(QBITS - 1)) begin
          w_state_nxt = S_ROUND;
        end else begin
          w_state_nxt = S_DIVIDE;
        end
      end
      S_ROUND: begin
        // Special operands take priority over the computed quotient.
        if (r_eb_zero || r_ea_zero) begin
          {w_q_nxt, w_flags_nxt} = special_result(r_sq, r_eb_zero);
        end else if (w_ovf) begin
          w_q_nxt     = {r_sq, 7'h7F};
          w_flags_nxt = 4'b0101;
        end else if (w_unf) begin
          w_q_nxt     = {r_sq, 7'h00};
          w_flags_nxt = 4'b0011;
        end else begin
          w_q_nxt     = {r_sq, w_ep_f[2:0], w_m_sum[3:0]};
          w_flags_nxt = {3'b000, w_g | w_r | w_s};
        end
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
    // in_ready is registered and follows the state actually entered.
    w_in_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_sq        <= 1'b0;
      r_ea_zero   <= 1'b0;
      r_eb_zero   <= 1'b0;
      r_mb        <= 5'd0;
      r_rem       <= 6'd0;
      r_quo       <= '0;
      r_ep        <= 5'sd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_q         <= 8'h00;
      r_flags     <= 4'h0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_sq        <= w_sq_nxt;
      r_ea_zero   <= w_ea_zero_nxt;
      r_eb_zero   <= w_eb_zero_nxt;
      r_mb        <= w_mb_nxt;
      r_rem       <= w_rem_nxt;
      r_quo       <= w_quo_nxt;
      r_ep        <= w_ep_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_q         <= w_q_nxt;
      r_flags     <= w_flags_nxt;
    end
  end

endmodule

// File: tb/tb_fp8_div_iterative.sv
// Directed testbench for fp8_div_iterative with a result scoreboard.
// Latency is counted in rising edges from the accept edge to the edge that
// raises out_valid: 8 for a normal divide, 0 for early-exit special operands.
module tb_fp8_div_iterative;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic [3:0] flags;

  int n_vec  = 0;
  int n_fail = 0;
  logic [11:0] sb[$];

`ifdef FPDIV_EARLY_EXIT_EN
  localparam int SPL = 0;
`else
  localparam int SPL = 8;
`endif
  localparam int NRM = 8;

  fp8_div_iterative dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for in_ready, present operands for one edge, record expectation.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] eq, input logic [3:0] ef);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
    sb.push_back({eq, ef});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall, then handshake.
  task automatic collect(input string tag, input int elat, input int hold);
    int lat;
    logic [11:0] e;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_q"}, 32'(q), 32'(e[11:4]));
      check({tag, "_flags"}, 32'(flags), 32'(e[3:0]));
      for (int i = 0; i < hold; i++) begin
        // Offer a new operation that must be ignored while the result is held.
        in_valid = 1'b1;
        a        = 8'h7F;
        b        = 8'h10;
        @(posedge clk);
        #1;
        check({tag, "_hold_q"}, 32'(q), 32'(e[11:4]));
        check({tag, "_hold_flags"}, 32'(flags), 32'(e[3:0]));
        check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                    input logic [7:0] eq, input logic [3:0] ef, input int elat);
    issue(ia, ib, eq, ef);
    collect(tag, elat, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(q), 32'h00);
    check("rst_flags", 32'(flags), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic quotients, rounding and sign.
    op("d1p5_1p0",  8'h38, 8'h30, 8'h38, 4'h0, NRM);
    op("d1p0_1p5",  8'h30, 8'h38, 8'h25, 4'b0001, NRM);
    op("neg2_1p0",  8'hC0, 8'h30, 8'hC0, 4'h0, NRM);
    op("rnd_up",    8'h3F, 8'h38, 8'h35, 4'b0001, NRM);
    op("neg_div",   8'h38, 8'hB0, 8'hB8, 4'h0, NRM);
    // Special operands.
    op("zero_div",  8'h00, 8'h38, 8'h00, 4'h0, SPL);
    op("negzero",   8'h80, 8'h38, 8'h80, 4'h0, SPL);
    op("div_by_0",  8'h38, 8'h00, 8'h7F, 4'b1000, SPL);
    op("zero_by_0", 8'h00, 8'h80, 8'hFF, 4'b1000, SPL);
    // Range boundaries.
    op("ovf",       8'h7F, 8'h10, 8'h7F, 4'b0101, NRM);
    op("unf",       8'h10, 8'h7F, 8'h00, 4'b0011, NRM);
    op("unf_ep0",   8'h10, 8'h38, 8'h00, 4'b0011, NRM);
    op("max_ep7",   8'h70, 8'h2F, 8'h71, 4'b0001, NRM);
    op("min_ep1",   8'h10, 8'h30, 8'h10, 4'h0, NRM);

    // Backpressure: result held for 5 clocks, offered operands ignored.
    issue(8'h3F, 8'h38, 8'h35, 4'b0001);
    collect("bp", NRM, 5);
    op("bp_next",   8'h30, 8'h30, 8'h30, 4'h0, NRM);

    // Asynchronous reset in the middle of DIVIDE (cnt == 3).
    issue(8'h38, 8'h30, 8'h38, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_q", 32'(q), 32'h00);
    check("midrst_flags", 32'(flags), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    op("after_rst", 8'h30, 8'h38, 8'h25, 4'b0001, NRM);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
